ram_march_bist: RTL and testbench
=================================

# ram_march_bist

Built-in self-test engine that drives the write port (A) and read port (B) of the team's simple dual-port RAM and checks its contents with a March C- style sequence. It is the initiator side of the RAM interface: it generates `ce`, `we`, `re`, addresses and write data, and consumes the registered read data. It sits between the RAM instance and the system controller, which starts a test and reads back pass/fail status.

## Interface
- `AW`, default 3: RAM address width; depth D = 2^AW.
- `DW`, default 8: RAM data width.

- `clk`, in, 1: clock. All state changes on the rising edge.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a test; sampled only in IDLE.
- `busy`, out, 1: test in progress.
- `done`, out, 1: test finished; level, held until the next accepted `start`.
- `pass`, out, 1: valid while `done`=1; 1 means no mismatch was found.
- `fail_addr`, out, AW: address of the first mismatch.
- `fail_elem`, out, 2: march element (0..3) of the first mismatch.
- `ram_ce`, out, 1: RAM chip enable; equals `busy`.
- `ram_we`, out, 1: RAM write enable (port A).
- `ram_re`, out, 1: RAM read enable (port B).
- `ram_adr_a`, out, AW: write address.
- `ram_adr_b`, out, AW: read address.
- `ram_din`, out, DW: write data; always all-0s or all-1s.
- `ram_dout`, in, DW: RAM read data; valid 1 cycle after the `re` edge.

## Operation
- The march sequence runs in four elements:
  - E0: ascending, write 0.
  - E1: ascending, read and expect 0, then write 1.
  - E2: descending, read and expect 1, then write 0.
  - E3: descending, read and expect 0.
- FSM states:
  - IDLE: waits for `start`.
  - WR: E0 only. One address per cycle with `ram_we`=1.
  - RD: drives `ram_re`=1 and `ram_adr_b`=addr.
  - CK: compares `ram_dout` with the expected value. In E1/E2 the same cycle drives `ram_we`=1, `ram_adr_a`=addr and the inverted data.
  - DONE: holds the result.
- Transitions:
  - IDLE→WR on `start`.
  - WR→WR until addr=D-1, then →RD with E1 and addr=0.
  - RD→CK.
  - CK→RD with the next address.
  - At the last address of an element, CK→RD of the next element, with addr reset to 0 (ascending) or D-1 (descending).
  - CK of E3 at addr 0→DONE.
- Mismatch in CK: capture `fail_addr`/`fail_elem` on the first mismatch only, suppress that cycle's write, clear `pass`, go to DONE.
- DONE→WR on `start`. Entering WR clears `pass` to 1 internally and clears `fail_*` to 0.
- `start` while `busy`=1 is ignored.
- Address counters wrap only at element boundaries and never run past 0 or D-1.
- When `ram_we`=0, `ram_adr_a` and `ram_din` hold their last values. When `ram_re`=0, `ram_adr_b` holds its last value.

## Timing
- Reset values: `busy`, `done`, `pass`, `fail_addr`, `fail_elem`, `ram_ce`, `ram_we`, `ram_re`, `ram_adr_a`, `ram_adr_b` and `ram_din` are all 0. The FSM is in IDLE.
- Edge t0 samples `start`=1. From t0 on, `busy`=1 and the first write (addr 0) is presented. RAM writes commit at edges t0+1..t0+D.
- Each read/check pair takes 2 cycles. Total: D + 3·2D = 7D cycles. `done` rises and `busy` falls at edge t0+7D (t0+56 for the defaults).
- Abort on mismatch: `done` rises at the edge after the failing CK cycle.
- `nrst` asserted mid-test: all outputs return immediately (asynchronously) to their reset values and the FSM returns to IDLE. RAM contents are not cleared.

## Configuration
- Macro `RAM_BIST_ERRCNT_EN`.
- Defined:
  - Adds output `err_cnt`, width AW+2. It saturates at its maximum value.
  - A mismatch increments `err_cnt`. The test continues to the end without aborting and the write is not suppressed.
  - `fail_*` still hold the first mismatch. `pass`=(`err_cnt`==0).
  - `err_cnt` resets to 0 and clears on an accepted `start`.
- Undefined: abort-on-first-fail behaviour as described above, and there is no `err_cnt` port.

## Structure
- Package `ram_bist_pkg`:
  - State enum: IDLE, WR, RD, CK, DONE.
  - Element encoding: E0..E3.
  - Per-element constants: direction, expected value, whether a write follows the read.
  - Default AW/DW.
- Sub-module `ram_bist_addr_gen`: an up/down address counter with load-to-first and a last-address flag.

## Test plan
- Fault-free RAM model, defaults, `start` pulse → `done`=1 at t0+56, `pass`=1, `busy`=0. `ram_we` is high for 24 cycles and `ram_re` for 24 cycles.
- Bit 0 of addr 5 stuck at 1 → first mismatch in E1 at addr 5 (read 0x01, expected 0x00). `done` rises 1 cycle after that CK; `pass`=0, `fail_addr`=5, `fail_elem`=1.
- Bit 7 of addr 2 stuck at 0 → `fail_elem`=2, `fail_addr`=2, `pass`=0.
- `nrst` pulsed low at t0+20 → all outputs are 0 during the pulse. A new `start` then runs a full 56-cycle test with `pass`=1.
- `start` held high through the whole run → no restart while busy. A new test begins on the edge after `done` rises if `start` is still 1.
- With `RAM_BIST_ERRCNT_EN`, bit 0 stuck-at-1 at addr 5 → full 56-cycle run, `err_cnt`=2 (from E1 and E3), `fail_elem`=1, `pass`=0.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and per-element march constants for the RAM march BIST engine.
package ram_bist_pkg;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 8;

  typedef enum logic [2:0] {IDLE, WR, RD, CK, DONE} state_t;
  typedef enum logic [1:0] {E0, E1, E2, E3} elem_t;

  typedef struct packed {
    logic down;
    logic expect_one;
    logic write_after;
  } elem_cfg_t;

  // E0 is write-only; its write_after bit marks it as a writing element.
  function automatic elem_cfg_t elem_cfg(elem_t e);
    elem_cfg_t c;
    c = '0;
    case (e)
      E0: c = '{down: 1'b0, expect_one: 1'b0, write_after: 1'b1};
      E1: c = '{down: 1'b0, expect_one: 1'b0, write_after: 1'b1};
      E2: c = '{down: 1'b1, expect_one: 1'b1, write_after: 1'b1};
      E3: c = '{down: 1'b1, expect_one: 1'b0, write_after: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter: load jumps to the first address of a direction,
// last flags the final address so the counter never runs past 0 or D-1.
module ram_bist_addr_gen #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          load,
  input  logic          load_down,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] TOP = '1;

  logic [AW-1:0] addr_reg;
  logic          down_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_reg <= '0;
      down_reg <= 1'b0;
    end else if (load) begin
      addr_reg <= load_down ? TOP : '0;
      down_reg <= load_down;
    end else if (step && !last) begin
      addr_reg <= down_reg ? addr_reg - AW'(1) : addr_reg + AW'(1);
    end
  end

  assign addr = addr_reg;
  assign last = down_reg ? (addr_reg == '0) : (addr_reg == TOP);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for the simple dual-port RAM.
// Optional RAM_BIST_ERRCNT_EN: count mismatches into err_cnt instead of aborting.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [1:0]    fail_elem,
`ifdef RAM_BIST_ERRCNT_EN
  output logic [AW+1:0] err_cnt,
`endif
  output logic          ram_ce,
  output logic          ram_we,
  output logic          ram_re,
  output logic [AW-1:0] ram_adr_a,
  output logic [AW-1:0] ram_adr_b,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

`ifdef RAM_BIST_ERRCNT_EN
  localparam bit ABORT = 1'b0;
`else
  localparam bit ABORT = 1'b1;
`endif

  state_t        state_reg, state_next;
  elem_t         elem_reg, elem_next;
  elem_cfg_t     cfg;
  logic          ag_load, ag_load_down, ag_step;
  logic [AW-1:0] addr;
  logic          last;
  logic [DW-1:0] expected;
  logic          mismatch, start_acc;
  logic          pass_reg;
  logic [AW-1:0] fail_addr_reg, adr_a_reg, adr_b_reg;
  logic [1:0]    fail_elem_reg;
  logic [DW-1:0] din_reg;

  ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk       (clk),
    .nrst      (nrst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .addr      (addr),
    .last      (last)
  );

  assign cfg       = elem_cfg(elem_reg);
  assign expected  = {DW{cfg.expect_one}};
  assign mismatch  = (state_reg == CK) && (ram_dout != expected);
  assign start_acc = ((state_reg == IDLE) || (state_reg == DONE)) && start;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      elem_reg  <= E0;
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    elem_next    = elem_reg;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = WR;
          elem_next  = E0;
          ag_load    = 1'b1;
        end
      end
      WR: begin
        if (last) begin
          state_next   = RD;
          elem_next    = E1;
          ag_load      = 1'b1;
          ag_load_down = elem_cfg(E1).down;
        end else begin
          ag_step = 1'b1;
        end
      end
      RD: state_next = CK;
      CK: begin
        if (mismatch && ABORT) begin
          state_next = DONE;
        end else if (last) begin
          if (elem_reg == E3) begin
            state_next = DONE;
          end else begin
            state_next   = RD;
            elem_next    = elem_t'(elem_reg + 2'd1);
            ag_load      = 1'b1;
            ag_load_down = elem_cfg(elem_next).down;
          end
        end else begin
          state_next = RD;
          ag_step    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses and write data fall back to their held copies when idle.
  always_comb begin
    busy      = (state_reg == WR) || (state_reg == RD) || (state_reg == CK);
    done      = (state_reg == DONE);
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_adr_a = adr_a_reg;
    ram_adr_b = adr_b_reg;
    ram_din   = din_reg;
    case (state_reg)
      WR: begin
        ram_we    = 1'b1;
        ram_adr_a = addr;
        ram_din   = '0;
      end
      RD: begin
        ram_re    = 1'b1;
        ram_adr_b = addr;
      end
      CK: begin
        if (cfg.write_after && !(mismatch && ABORT)) begin
          ram_we    = 1'b1;
          ram_adr_a = addr;
          ram_din   = {DW{~cfg.expect_one}};
        end
      end
      default: ;
    endcase
  end

  assign ram_ce    = busy;
  assign pass      = done & pass_reg;
  assign fail_addr = fail_addr_reg;
  assign fail_elem = fail_elem_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      adr_a_reg     <= '0;
      adr_b_reg     <= '0;
      din_reg       <= '0;
      pass_reg      <= 1'b0;
      fail_addr_reg <= '0;
      fail_elem_reg <= '0;
    end else begin
      adr_a_reg <= ram_adr_a;
      adr_b_reg <= ram_adr_b;
      din_reg   <= ram_din;
      if (start_acc) begin
        pass_reg      <= 1'b1;
        fail_addr_reg <= '0;
        fail_elem_reg <= '0;
      end else if (mismatch && pass_reg) begin
        pass_reg      <= 1'b0;
        fail_addr_reg <= addr;
        fail_elem_reg <= elem_reg;
      end
    end
  end

`ifdef RAM_BIST_ERRCNT_EN
  logic [AW+1:0] err_cnt_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_cnt_reg <= '0;
    end else if (start_acc) begin
      err_cnt_reg <= '0;
    end else if (mismatch && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + (AW+2)'(1);
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a fault-injectable dual-port RAM model.
`timescale 1ns/1ps
module tb_ram_march_bist;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [1:0]    fail_elem;
`ifdef RAM_BIST_ERRCNT_EN
  logic [AW+1:0] err_cnt;
`endif
  logic          ram_ce, ram_we, ram_re;
  logic [AW-1:0] ram_adr_a, ram_adr_b;
  logic [DW-1:0] ram_din, ram_dout;

  ram_march_bist #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
`ifdef RAM_BIST_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_adr_a (ram_adr_a),
    .ram_adr_b (ram_adr_b),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM with one faulty cell: stuck-at masks are applied to stored data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_sa1 = '0;
  logic [DW-1:0] f_sa0 = '0;

  always @(posedge clk) begin
    if (ram_ce && ram_we)
      mem[ram_adr_a] <= (ram_adr_a == f_addr) ? ((ram_din | f_sa1) & ~f_sa0) : ram_din;
    if (ram_ce && ram_re)
      ram_dout <= mem[ram_adr_b];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    if (ram_we) we_cnt++;
    if (ram_re) re_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int c);
    for (int i = 0; i < c; i++) tick();
  endtask

  task automatic run_to_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
    we_cnt = 0;
    re_cnt = 0;
  endtask

  initial begin
    nrst  = 1'b0;
    start = 1'b0;
    #12;
    chk("rst_outputs", {busy, done, pass, fail_addr, fail_elem, ram_ce, ram_we, ram_re,
                        ram_adr_a, ram_adr_b, ram_din}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    ticks(2);
    chk("idle_busy", busy, 1'b0);

    // Fault-free run with mid-run protocol checks.
    kick();
    chk("t0_busy", {busy, ram_ce}, 2'b11);
    chk("t0_write", {ram_we, ram_adr_a, ram_din}, {1'b1, 3'd0, 8'h00});
    ticks(14);
    chk("e1_rd_a3", {ram_re, ram_adr_b, ram_we, ram_adr_a, ram_din}, {1'b1, 3'd3, 1'b0, 3'd2, 8'hFF});
    tick();
    chk("e1_ck_a3", {ram_re, ram_adr_b, ram_we, ram_adr_a, ram_din}, {1'b0, 3'd3, 1'b1, 3'd3, 8'hFF});
    ticks(10);
    chk("e2_ck_a7", {ram_we, ram_adr_a, ram_din}, {1'b1, 3'd7, 8'h00});
    run_to_done(n);
    chk("ok_cycles", 25 + n, 56);
    chk("ok_pass", {done, pass, busy}, 3'b110);
    chk("ok_fail_info", {fail_addr, fail_elem}, 5'd0);
    chk("ok_we_cnt", we_cnt, 24);
    chk("ok_re_cnt", re_cnt, 24);
`ifdef RAM_BIST_ERRCNT_EN
    chk("ok_err_cnt", err_cnt, 5'd0);
`endif
    ticks(3);
    chk("done_held", {done, pass}, 2'b11);

    // Stuck-at-1 on bit 0 of address 5.
    f_addr = 3'd5; f_sa1 = 8'h01; f_sa0 = 8'h00;
    kick();
    chk("sa1_restart", {busy, done}, 2'b10);
    ticks(19);
`ifdef RAM_BIST_ERRCNT_EN
    chk("sa1_ck_we", ram_we, 1'b1);
    run_to_done(n);
    chk("sa1_cycles", 19 + n, 56);
    chk("sa1_err_cnt", err_cnt, 5'd2);
`else
    chk("sa1_ck_we", ram_we, 1'b0);
    run_to_done(n);
    chk("sa1_cycles", 19 + n, 20);
`endif
    chk("sa1_result", {done, pass, busy}, 3'b100);
    chk("sa1_fail_info", {fail_addr, fail_elem}, {3'd5, 2'd1});

    // Stuck-at-0 on bit 7 of address 2.
    f_addr = 3'd2; f_sa1 = 8'h00; f_sa0 = 8'h80;
    kick();
    run_to_done(n);
`ifdef RAM_BIST_ERRCNT_EN
    chk("sa0_cycles", n, 56);
    chk("sa0_err_cnt", err_cnt, 5'd1);
`else
    chk("sa0_cycles", n, 36);
`endif
    chk("sa0_result", {done, pass}, 2'b10);
    chk("sa0_fail_info", {fail_addr, fail_elem}, {3'd2, 2'd2});

    // Reset pulse at t0+20, then a clean rerun.
    f_sa0 = 8'h00;
    kick();
    ticks(20);
    chk("pre_rst_rd", {busy, ram_re, ram_adr_b}, {1'b1, 1'b1, 3'd6});
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, done, pass, fail_addr, fail_elem, ram_ce, ram_we, ram_re,
                         ram_adr_a, ram_adr_b, ram_din}, 32'h0);
    tick();
    chk("rst_hold_outs", {busy, ram_ce, ram_we, ram_re, ram_adr_a, ram_adr_b, ram_din}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    kick();
    run_to_done(n);
    chk("post_rst_cyc", n, 56);
    chk("post_rst_pass", {done, pass}, 2'b11);

    // Start held high: ignored while busy, restarts right after done.
    start = 1'b1;
    tick();
    run_to_done(n);
    chk("held_cycles", n, 56);
    chk("held_done", {done, pass}, 2'b11);
    tick();
    chk("held_restart", {busy, done}, 2'b10);
    start = 1'b0;
    run_to_done(n);
    chk("held_rerun", n, 56);
    chk("held_pass", {done, pass}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
